// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared types for the HWPE lane splitter
// Purpose: skid-buffer state encoding and the default-geometry request entry.
// Ports: none (package).
package hci_package;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } hci_lane_split_state_e;

    // Default geometry; the top re-declares the entry at its own widths
    // with identical field names and hands it to the skid buffer as a type.
    localparam int unsigned HCI_NB_LANES = 2;
    localparam int unsigned HCI_DW       = 32;
    localparam int unsigned HCI_AW       = 32;

    typedef struct packed {
        logic [HCI_AW-1:0]                add;
        logic                             wen;
        logic [HCI_NB_LANES*HCI_DW/8-1:0] be;
        logic [HCI_NB_LANES*HCI_DW-1:0]   data;
    } hci_lane_entry_t;

endpackage

// File: rtl/hci_hwpe_skid_buffer.sv
// rtl/hci_hwpe_skid_buffer.sv - two-entry skid buffer with registered ready
// Purpose: absorbs up to two requests so that ready_o depends on state only.
// Ports: clk_i, rst_i (sync, active high), clear_i (sync soft clear),
//        valid_i/ready_o/data_i upstream, valid_o/ready_i/data_o downstream (head).
module hci_hwpe_skid_buffer
    import hci_package::*;
#(
    parameter type entry_t = hci_lane_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  logic   valid_i,
    output logic   ready_o,
    input  entry_t data_i,
    output logic   valid_o,
    input  logic   ready_i,
    output entry_t data_o
);

    hci_lane_split_state_e state_q, state_d;
    entry_t                head_q, head_d;
    entry_t                skid_q, skid_d;
    logic                  push, pop;

    // Ready comes from the registered state, which breaks the grant path
    // back from the downstream AND-of-bank-grants.
    assign ready_o = (state_q != TWO) & ~rst_i;
    assign valid_o = (state_q != EMPTY);
    assign data_o  = head_q;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = data_i;
                end else if (push) begin
                    skid_d  = data_i;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/hci_hwpe_lane_splitter.sv
// rtl/hci_hwpe_lane_splitter.sv - splits a wide TCDM request into word lanes
// Purpose: buffers wide requests, fans them out to NB_LANES lane ports with
//          per-lane addresses, exports the bank rotation and reassembles responses.
// Ports: clk_i, rst_i, clear_i; in_* wide slave port (req/gnt/add/wen/be/data,
//        r_data/r_valid); out_* per-lane master ports; order_o bank rotation.
module hci_hwpe_lane_splitter
    import hci_package::*;
#(
    parameter int unsigned NB_LANES = 2,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 32,
    localparam int unsigned BW      = DW / 8,
    localparam int unsigned WO      = $clog2(BW),
    localparam int unsigned LB      = $clog2(NB_LANES)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              in_req,
    output logic                              in_gnt,
    input  logic [AW-1:0]                     in_add,
    input  logic                              in_wen,
    input  logic [NB_LANES*BW-1:0]            in_be,
    input  logic [NB_LANES*DW-1:0]            in_data,
    output logic [NB_LANES*DW-1:0]            in_r_data,
    output logic                              in_r_valid,
    output logic [NB_LANES-1:0]               out_req,
    input  logic [NB_LANES-1:0]               out_gnt,
    output logic [NB_LANES-1:0][AW-1:0]       out_add,
    output logic [NB_LANES-1:0]               out_wen,
    output logic [NB_LANES-1:0][BW-1:0]       out_be,
    output logic [NB_LANES-1:0][DW-1:0]       out_data,
    input  logic [NB_LANES-1:0][DW-1:0]       out_r_data,
    input  logic [NB_LANES-1:0]               out_r_valid,
    output logic [LB-1:0]                     order_o
);

    typedef struct packed {
        logic [AW-1:0]          add;
        logic                   wen;
        logic [NB_LANES*BW-1:0] be;
        logic [NB_LANES*DW-1:0] data;
    } entry_t;

    entry_t        in_entry, head;
    logic          head_valid;
    logic [AW-1:0] base_add;
    logic          unused_bits;

    assign in_entry = '{add: in_add, wen: in_wen, be: in_be, data: in_data};

    hci_hwpe_skid_buffer #(
        .entry_t (entry_t)
    ) i_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .valid_i (in_req),
        .ready_o (in_gnt),
        .data_i  (in_entry),
        .valid_o (head_valid),
        .ready_i (out_gnt[0]),
        .data_o  (head)
    );

    // Byte offset within a word is dropped; byte selection travels in be.
    assign base_add = {head.add[AW-1:WO], {WO{1'b0}}};

    // The head register only changes when a new head is loaded and keeps its
    // contents after the last pop, so the rotation holds while empty.
    assign order_o = head.add[WO +: LB];

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        assign out_req[k]  = head_valid;
        assign out_wen[k]  = head.wen;
        assign out_data[k] = head.data[k*DW +: DW];
        assign out_be[k]   = head.be[k*BW +: BW];
        assign out_add[k]  = base_add + AW'(k * BW);
        assign in_r_data[k*DW +: DW] = out_r_data[k];
    end

    // The reorder stage grants and responds on lane 0 only.
    assign in_r_valid = out_r_valid[0] & ~rst_i;

    assign unused_bits = ^{head.add[WO-1:0], out_gnt[NB_LANES-1:1],
                           out_r_valid[NB_LANES-1:1]};

endmodule

// File: tb/tb_hci_hwpe_lane_splitter.sv
// tb/tb_hci_hwpe_lane_splitter.sv - directed self-checking bench for the lane splitter
module tb_hci_hwpe_lane_splitter;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    clear_i;
    logic                    in_req;
    logic                    in_gnt;
    logic [AW-1:0]           in_add;
    logic                    in_wen;
    logic [NL*BW-1:0]        in_be;
    logic [NL*DW-1:0]        in_data;
    logic [NL*DW-1:0]        in_r_data;
    logic                    in_r_valid;
    logic [NL-1:0]           out_req;
    logic [NL-1:0]           out_gnt;
    logic [NL-1:0][AW-1:0]   out_add;
    logic [NL-1:0]           out_wen;
    logic [NL-1:0][BW-1:0]   out_be;
    logic [NL-1:0][DW-1:0]   out_data;
    logic [NL-1:0][DW-1:0]   out_r_data;
    logic [NL-1:0]           out_r_valid;
    logic [1:0]              order_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    hci_hwpe_lane_splitter #(
        .NB_LANES (NL),
        .DW       (DW),
        .AW       (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_req      (in_req),
        .in_gnt      (in_gnt),
        .in_add      (in_add),
        .in_wen      (in_wen),
        .in_be       (in_be),
        .in_data     (in_data),
        .in_r_data   (in_r_data),
        .in_r_valid  (in_r_valid),
        .out_req     (out_req),
        .out_gnt     (out_gnt),
        .out_add     (out_add),
        .out_wen     (out_wen),
        .out_be      (out_be),
        .out_data    (out_data),
        .out_r_data  (out_r_data),
        .out_r_valid (out_r_valid),
        .order_o     (order_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        in_req      = 1'b0;
        in_add      = '0;
        in_wen      = 1'b1;
        in_be       = '1;
        in_data     = '0;
        out_gnt     = '0;
        out_r_data  = '0;
        out_r_valid = '0;

        // Reset held for three cycles
        tick(); tick(); tick();
        chk("gnt_in_reset", in_gnt, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("gnt_after_reset", in_gnt, 1'b1);
        chk("req_after_reset", out_req, 4'h0);
        chk("order_after_reset", order_o, 2'd0);

        // Read split
        in_req  = 1'b1;
        in_add  = 32'h0000_1008;
        out_gnt = 4'hF;
        tick();
        in_req = 1'b0;
        chk("split_req", out_req, 4'hF);
        chk("split_adds", out_add, 128'h00001014_00001010_0000100C_00001008);
        chk("split_order", order_o, 2'd2);
        chk("split_wen", out_wen, 4'hF);
        tick();
        chk("split_req_after_pop", out_req, 4'h0);
        out_r_data  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        out_r_valid = 4'hF;
        #1;
        chk("resp_data", in_r_data, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        chk("resp_valid", in_r_valid, 1'b1);
        tick();
        out_r_valid = 4'h0;
        #1;
        chk("resp_valid_low", in_r_valid, 1'b0);

        // Backpressure: three back-to-back pushes with lane-0 grant low
        out_gnt = 4'h0;
        in_req  = 1'b1;
        in_add  = 32'h0000_2000;
        #1;
        chk("bp_gnt1", in_gnt, 1'b1);
        tick();
        in_add = 32'h0000_2004;
        #1;
        chk("bp_gnt2", in_gnt, 1'b1);
        tick();
        in_add = 32'h0000_2008;
        #1;
        chk("bp_gnt3_blocked", in_gnt, 1'b0);
        chk("bp_head_add", out_add[0], 32'h0000_2000);
        tick();
        chk("bp_still_blocked", in_gnt, 1'b0);
        chk("bp_head_stable", out_add[0], 32'h0000_2000);
        chk("bp_order_first", order_o, 2'd0);
        out_gnt = 4'hF;
        tick();
        chk("bp_pop2_add", out_add[0], 32'h0000_2004);
        chk("bp_pop2_order", order_o, 2'd1);
        chk("bp_gnt_reopen", in_gnt, 1'b1);
        tick();
        in_req = 1'b0;
        chk("bp_pop3_add", out_add[0], 32'h0000_2008);
        chk("bp_pop3_order", order_o, 2'd2);
        chk("bp_pop3_req", out_req, 4'hF);
        tick();
        chk("bp_drained", out_req, 4'h0);
        chk("bp_order_hold", order_o, 2'd2);

        // Address wrap
        in_req = 1'b1;
        in_add = 32'hFFFF_FFF8;
        tick();
        in_req = 1'b0;
        chk("wrap_adds", out_add, 128'h00000004_00000000_FFFFFFFC_FFFFFFF8);
        chk("wrap_order", order_o, 2'd2);
        tick();

        // Write masking
        in_req  = 1'b1;
        in_add  = 32'h0000_3000;
        in_wen  = 1'b0;
        in_be   = 16'h00F0;
        in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        tick();
        in_req = 1'b0;
        chk("wr_req", out_req, 4'hF);
        chk("wr_wen", out_wen, 4'h0);
        chk("wr_be", out_be, 16'h00F0);
        chk("wr_lane1_data", out_data[1], 32'h22222222);
        chk("wr_lane3_data", out_data[3], 32'h44444444);
        tick();
        in_wen = 1'b1;
        in_be  = '1;

        // Clear while holding two entries
        out_gnt = 4'h0;
        in_req  = 1'b1;
        in_add  = 32'h0000_4004;
        tick();
        in_add = 32'h0000_4008;
        tick();
        in_req = 1'b0;
        chk("clr_full", in_gnt, 1'b0);
        chk("clr_order_before", order_o, 2'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_req", out_req, 4'h0);
        chk("clr_gnt", in_gnt, 1'b1);
        chk("clr_order", order_o, 2'd0);

        // Reset mid-operation discards the head
        in_req = 1'b1;
        in_add = 32'h0000_500C;
        tick();
        in_req = 1'b0;
        chk("mid_req_before_rst", out_req, 4'hF);
        rst_i = 1'b1;
        #1;
        chk("mid_gnt_in_rst", in_gnt, 1'b0);
        tick();
        rst_i = 1'b0;
        chk("mid_req_after_rst", out_req, 4'h0);
        chk("mid_order_after_rst", order_o, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hci_hwpe_lane_splitter.md
# hci_hwpe_lane_splitter

Upstream stage of the HWPE lane-reordering crossbar. Accepts one wide TCDM request per cycle from an HWPE streamer, buffers it in a two-entry skid buffer, and splits it into NB_LANES word-wide lane requests with per-lane addresses. It also produces the bank rotation (`order_o`) that the reorder stage consumes, and reassembles the lane responses into one wide response. The registered `in.gnt` cuts the combinational grant path from the reorder stage, whose grant is the AND of all bank grants.

## Interface
- NB_LANES, 2: number of word lanes; power of two, ≥2.
- DW, 32: lane data width in bits; wide width is NB_LANES*DW.
- AW, 32: address width.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i on state.
- in  hwpe_stream_intf_tcdm.slave  DATA_WIDTH=NB_LANES*DW  wide request/response port.
- out[NB_LANES-1:0]  hwpe_stream_intf_tcdm.master  DATA_WIDTH=DW  lane ports toward the reorder stage.
- order_o  out  $clog2(NB_LANES)  bank rotation for the reorder stage.

## Operation
- Word offset: WO = $clog2(DW/8).
- Lane field: LB = $clog2(NB_LANES).
- Skid FSM states:
  - EMPTY: no entries.
  - ONE: head valid.
  - TWO: head and skid valid.
- Transitions:
  - push = in.req & in.gnt.
  - pop = head valid & out[0].gnt. Only lane 0's grant is consulted, because the reorder stage drives grant on lane 0 only.
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; pop & !push → EMPTY; push & pop → ONE, with the new request loaded into head.
  - TWO: pop → ONE, with skid moving to head. No push is possible in TWO.
- `in.gnt` = (state != TWO) & !rst_i. It is decoded from the registered state only.
- Each entry holds: add, wen, be (NB_LANES*DW/8 bits), data (NB_LANES*DW bits).
- Lane k, driven from head:
  - req = head valid
  - wen = head wen
  - data = head data[k*DW +: DW]
  - be = head be[k*DW/8 +: DW/8]
  - add = ({head.add[AW-1:WO], WO'b0} + k*DW/8) mod 2^AW
- Address low bits [WO-1:0] are dropped. Byte selection is carried by be only.
- `order_o` = head.add[WO +: LB]. It is registered whenever a new head is loaded and holds its last value while EMPTY.
- Response reassembly:
  - in.r_data[k*DW +: DW] = out[k].r_data.
  - in.r_valid = out[0].r_valid & !rst_i.
  - This path is combinational, and the response passes through in request order.

## Timing
- Reset and clear values: state EMPTY, order_o = 0, all out[k].req = 0, all entry fields 0.
  - in.gnt = 0 while rst_i is high and 1 the cycle after release.
  - clear_i forces EMPTY in the following cycle. Responses still in flight are passed through.
- Request latency: a push in cycle t appears on out in cycle t+1 if the buffer was EMPTY. Otherwise it appears after all older entries have popped.
- Response latency: wide response at pop cycle + 1, because the reorder stage has fixed latency 1.
- Throughput: one request per cycle with continuous out[0].gnt.
- Backpressure: at most 2 requests are absorbed. in.gnt drops the cycle after the second one is accepted.
- out[k] request fields are stable while req is high and not granted. Ordering is strictly FIFO.
- Reset mid-operation: both entries are discarded. No lane req is issued after the reset cycle.

## Structure
- Put `hci_lane_split_state_e` (EMPTY/ONE/TWO) and the entry struct typedef (`add`, `wen`, `be`, `data`) in `hci_package`.
- One sub-module, `hci_hwpe_skid_buffer`: a two-entry, registered-ready skid buffer over the entry struct.
- The top level does the lane split, address arithmetic, the order register and response concatenation.

## Test plan
- Reset: hold rst_i for 3 cycles, then release → in.gnt = 1, all out[k].req = 0, order_o = 0.
- Read split (NB_LANES=4, DW=32): push add 0x1008, out[0].gnt = 1 → next cycle the lane adds are 0x1008, 0x100C, 0x1010, 0x1014 and order_o = 2. Lane r_data {D,C,B,A} one cycle later → in.r_data = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
- Backpressure: out[0].gnt = 0, three back-to-back pushes → two accepted and in.gnt = 0 for the third. Release gnt → pops appear in push order and the third request is then accepted.
- Address wrap: push add 0xFFFF_FFF8 → lane adds 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; order_o = 2.
- Write masking: wen = 0, be = 0x00F0, data = 0x4444_3333_2222_1111 per lane → lane1 be = 0xF and other lanes be = 0x0. All lanes req, and lane1 data = 0x2222.
- Clear while in TWO: assert clear_i for one cycle → next cycle state EMPTY, all req = 0, in.gnt = 1.
